// File: rtl/cv32e40x_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_rvfi_pkg
// Description : Shared types and constants for the RVFI trace serializer.
//               NMEM    - memory slots carried by each retired record
//               SLOT_W  - width of a slot index (at least 1 bit)
//               rvfi_trace_rec_t - one buffered retired-instruction record
//               active_slots()   - per-slot "has a memory operation" vector
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40x_rvfi_pkg;

    localparam int NMEM   = 2;
    localparam int SLOT_W = (NMEM > 1) ? $clog2(NMEM) : 1;

    typedef struct packed {
        logic [31:0]          pc_rdata;
        logic [31:0]          rs1_rdata;
        logic [31:0]          rs2_rdata;
        logic [31:0]          rd_wdata;
        logic [4:0]           rs1_addr;
        logic [4:0]           rs2_addr;
        logic [4:0]           rd_addr;
        logic [32*NMEM-1:0]   mem_addr;
        logic [32*NMEM-1:0]   mem_rdata;
        logic [32*NMEM-1:0]   mem_wdata;
        logic [4*NMEM-1:0]    mem_rmask;
        logic [4*NMEM-1:0]    mem_wmask;
    } rvfi_trace_rec_t;

    // A slot carries a memory operation when either byte mask is non-zero.
    function automatic logic [NMEM-1:0] active_slots(input rvfi_trace_rec_t rec);
        logic [NMEM-1:0] act;
        act = '0;
        for (int i = 0; i < NMEM; i++) begin
            act[i] = (|rec.mem_rmask[4*i +: 4]) || (|rec.mem_wmask[4*i +: 4]);
        end
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40x_rvfi_trace_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_rvfi_trace_serializer_if
// Description : Trace beat bus between the serializer (master) and the
//               instruction-trace consumer (slave). valid/ready handshake;
//               a beat carries the head record's register fields plus the
//               memory fields of one slot, its index and a last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40x_rvfi_trace_serializer_if import cv32e40x_rvfi_pkg::*; ();

    logic              trace_valid;
    logic              trace_ready;
    logic [31:0]       trace_pc;
    logic [31:0]       trace_rs1_rdata;
    logic [31:0]       trace_rs2_rdata;
    logic [31:0]       trace_rd_wdata;
    logic [4:0]        trace_rs1_addr;
    logic [4:0]        trace_rs2_addr;
    logic [4:0]        trace_rd_addr;
    logic [31:0]       trace_mem_addr;
    logic [31:0]       trace_mem_rdata;
    logic [31:0]       trace_mem_wdata;
    logic [3:0]        trace_mem_rmask;
    logic [3:0]        trace_mem_wmask;
    logic [SLOT_W-1:0] trace_slot;
    logic              trace_last;

    modport master (
        output trace_valid, trace_pc, trace_rs1_rdata, trace_rs2_rdata,
               trace_rd_wdata, trace_rs1_addr, trace_rs2_addr, trace_rd_addr,
               trace_mem_addr, trace_mem_rdata, trace_mem_wdata,
               trace_mem_rmask, trace_mem_wmask, trace_slot, trace_last,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_pc, trace_rs1_rdata, trace_rs2_rdata,
               trace_rd_wdata, trace_rs1_addr, trace_rs2_addr, trace_rd_addr,
               trace_mem_addr, trace_mem_rdata, trace_mem_wdata,
               trace_mem_rmask, trace_mem_wmask, trace_slot, trace_last,
        output trace_ready
    );

endinterface
`default_nettype wire

// File: rtl/cv32e40x_rvfi_slot_find.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_rvfi_slot_find
// Description : Combinational priority finder. Returns the lowest active
//               slot whose index is >= i_start, with a found flag.
//   i_active [NMEM]     per-slot active vector
//   i_start  [SLOT_W+1] lowest index to consider (one extra bit so that
//                       "one past the last slot" is representable)
//   o_found             some active slot at or above i_start exists
//   o_slot   [SLOT_W]   that slot (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40x_rvfi_slot_find import cv32e40x_rvfi_pkg::*; (
    input  wire logic [NMEM-1:0]   i_active,
    input  wire logic [SLOT_W:0]   i_start,
    output logic                   o_found,
    output logic [SLOT_W-1:0]      o_slot
);

    // Scan downwards so the lowest qualifying index wins.
    always_comb begin
        o_found = 1'b0;
        o_slot  = '0;
        for (int i = NMEM - 1; i >= 0; i--) begin
            if (i_active[i] && ((SLOT_W+1)'(i) >= i_start)) begin
                o_found = 1'b1;
                o_slot  = SLOT_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv32e40x_rvfi_trace_serializer.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_rvfi_trace_serializer
// Description : Buffers RVFI retired-instruction records in a DEPTH-entry
//               FIFO and emits one trace beat per active memory slot of the
//               head record (one beat if none are active). Records arriving
//               while full are dropped; overflow is sticky until reset.
//   clk, rst_n           clock, asynchronous active-low reset
//   rvfi_*               retired record input (no backpressure)
//   trace_if (master)    trace beat bus with valid/ready
//   overflow             sticky drop flag
//   drop_cnt             saturating drop count
// Build macro : CV32E40X_RVFI_TRACE_DROP_CNT_EN - builds the drop counter;
//               when undefined drop_cnt is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40x_rvfi_trace_serializer import cv32e40x_rvfi_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 rvfi_valid,
    input  wire logic [31:0]          rvfi_pc_rdata,
    input  wire logic [31:0]          rvfi_rs1_rdata,
    input  wire logic [31:0]          rvfi_rs2_rdata,
    input  wire logic [31:0]          rvfi_rd_wdata,
    input  wire logic [4:0]           rvfi_rs1_addr,
    input  wire logic [4:0]           rvfi_rs2_addr,
    input  wire logic [4:0]           rvfi_rd_addr,
    input  wire logic [32*NMEM-1:0]   rvfi_mem_addr,
    input  wire logic [32*NMEM-1:0]   rvfi_mem_rdata,
    input  wire logic [32*NMEM-1:0]   rvfi_mem_wdata,
    input  wire logic [4*NMEM-1:0]    rvfi_mem_rmask,
    input  wire logic [4*NMEM-1:0]    rvfi_mem_wmask,
    cv32e40x_rvfi_trace_serializer_if.master trace_if,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_EMIT  = 1'b1
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [c_PTR_W:0]      r_count;
    logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    rvfi_trace_rec_t       r_mem [DEPTH];
    rvfi_trace_rec_t       w_in_rec, w_head;
    logic                  r_overflow;

    // r_fresh marks a head record that has not emitted any beat yet; its
    // current slot is then the first active slot, found combinationally.
    logic                  r_fresh;
    logic [SLOT_W-1:0]     r_cur_slot;

    logic [NMEM-1:0]       w_active;
    logic                  w_first_found, w_next_found;
    logic [SLOT_W-1:0]     w_first_slot, w_next_slot, w_slot;
    logic                  w_full, w_push, w_drop;
    logic                  w_valid, w_last, w_hs, w_pop, w_advance;

    assign w_in_rec = '{pc_rdata: rvfi_pc_rdata, rs1_rdata: rvfi_rs1_rdata,
                        rs2_rdata: rvfi_rs2_rdata, rd_wdata: rvfi_rd_wdata,
                        rs1_addr: rvfi_rs1_addr, rs2_addr: rvfi_rs2_addr,
                        rd_addr: rvfi_rd_addr, mem_addr: rvfi_mem_addr,
                        mem_rdata: rvfi_mem_rdata, mem_wdata: rvfi_mem_wdata,
                        mem_rmask: rvfi_mem_rmask, mem_wmask: rvfi_mem_wmask};

    // Full test uses the registered count: a push alongside a final pop on a
    // full buffer is still dropped.
    assign w_full = (r_count == (c_PTR_W+1)'(DEPTH));
    assign w_push = rvfi_valid && !w_full;
    assign w_drop = rvfi_valid && w_full;

    assign w_head   = r_mem[r_rd_ptr];
    assign w_active = active_slots(w_head);

    cv32e40x_rvfi_slot_find u_find_first (
        .i_active (w_active),
        .i_start  ('0),
        .o_found  (w_first_found),
        .o_slot   (w_first_slot)
    );

    assign w_slot = r_fresh ? (w_first_found ? w_first_slot : '0) : r_cur_slot;

    cv32e40x_rvfi_slot_find u_find_next (
        .i_active (w_active),
        .i_start  ({1'b0, w_slot} + (SLOT_W+1)'(1)),
        .o_found  (w_next_found),
        .o_slot   (w_next_slot)
    );

    assign w_valid   = (r_state == S_EMIT);
    assign w_last    = !w_next_found;
    assign w_hs      = w_valid && trace_if.trace_ready;
    assign w_pop     = w_hs && w_last;
    assign w_advance = w_hs && !w_last;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_pop && !w_push && (r_count == (c_PTR_W+1)'(1)))
                         w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fresh    <= 1'b1;
            r_cur_slot <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (c_PTR_W+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (c_PTR_W+1)'(1);
            if (w_pop) begin
                r_fresh    <= 1'b1;
                r_cur_slot <= '0;
            end else if (w_advance) begin
                r_fresh    <= 1'b0;
                r_cur_slot <= w_next_slot;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Record storage needs no reset: nothing is read while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_rec;
    end

    assign overflow = r_overflow;

`ifdef CV32E40X_RVFI_TRACE_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

    // Outputs are forced to zero while idle so reset/empty state is clean.
    assign trace_if.trace_valid     = w_valid;
    assign trace_if.trace_pc        = w_valid ? w_head.pc_rdata  : '0;
    assign trace_if.trace_rs1_rdata = w_valid ? w_head.rs1_rdata : '0;
    assign trace_if.trace_rs2_rdata = w_valid ? w_head.rs2_rdata : '0;
    assign trace_if.trace_rd_wdata  = w_valid ? w_head.rd_wdata  : '0;
    assign trace_if.trace_rs1_addr  = w_valid ? w_head.rs1_addr  : '0;
    assign trace_if.trace_rs2_addr  = w_valid ? w_head.rs2_addr  : '0;
    assign trace_if.trace_rd_addr   = w_valid ? w_head.rd_addr   : '0;
    assign trace_if.trace_mem_addr  = w_valid ? w_head.mem_addr[32*w_slot +: 32]  : '0;
    assign trace_if.trace_mem_rdata = w_valid ? w_head.mem_rdata[32*w_slot +: 32] : '0;
    assign trace_if.trace_mem_wdata = w_valid ? w_head.mem_wdata[32*w_slot +: 32] : '0;
    assign trace_if.trace_mem_rmask = w_valid ? w_head.mem_rmask[4*w_slot +: 4]   : '0;
    assign trace_if.trace_mem_wmask = w_valid ? w_head.mem_wmask[4*w_slot +: 4]   : '0;
    assign trace_if.trace_slot      = w_valid ? w_slot : '0;
    assign trace_if.trace_last      = w_valid && w_last;

endmodule
`default_nettype wire
